regfile_mp: RTL and testbench
=============================

REGFILE_MP -- requirements
Module: regfile_mp

Interface
REQ-001 SHALL have parameter DATA_W, default 32, register data width in bits.
REQ-002 SHALL have parameter ADDR_W, default 4, register address width; DEPTH = 2**ADDR_W entries.
REQ-003 SHALL have parameter NREAD, default 2, number of combinational read ports (1..4).
REQ-004 SHALL have parameter PC_IDX, default 15, the register index whose reads return pc_in.
REQ-005 SHALL have port clk  input  1  single clock; all state updates on rising edge.
REQ-006 SHALL have port rst_n  input  1  synchronous, active-low reset.
REQ-007 SHALL have port we  input  1  write enable.
REQ-008 SHALL have port wa  input  ADDR_W  write address.
REQ-009 SHALL have port wd  input  DATA_W  write data.
REQ-010 SHALL have port ra  input  NREAD x ADDR_W  read addresses, one per port.
REQ-011 SHALL have port pc_in  input  DATA_W  PC+8 value returned for reads of PC_IDX.
REQ-012 SHALL have port rd  output  NREAD x DATA_W  read data, one per port.
REQ-013 SHALL have port busy  output  1  high while the clear sweep runs; writes ignored, reads return 0.

Function
REQ-014 SHALL implement a two-state FSM: CLEAR and READY.
REQ-015 In CLEAR, each rising edge SHALL write 0 to entry clr_cnt and increment clr_cnt by 1.
REQ-016 When clr_cnt == DEPTH-1 in CLEAR, that edge SHALL clear the last entry and move to READY; the sweep takes exactly DEPTH edges after rst_n goes high.
REQ-017 READY SHALL be held until rst_n is low; there is no other transition out of READY.
REQ-018 busy SHALL be 1 in CLEAR and 0 in READY.
REQ-019 In READY, on a rising edge with we=1 and wa != PC_IDX, entry wa SHALL take wd.
REQ-020 A write with wa == PC_IDX SHALL be dropped, with no storage change.
REQ-021 we SHALL be ignored while busy=1.
REQ-022 rd[i] SHALL be combinational: 0 if busy; else pc_in if ra[i] == PC_IDX; else entry ra[i] (or the bypass value, REQ-028).
REQ-023 Multiple ports addressing the same entry SHALL all return identical data.
REQ-024 Read-before-write timing: without bypass, a read in the same cycle as a write to that address SHALL return the old value.

Reset
REQ-025 While rst_n=0 at a rising edge: state SHALL become CLEAR, clr_cnt 0, busy 1; storage SHALL not be written on that edge.
REQ-026 rst_n low during a sweep or in READY SHALL restart the sweep from clr_cnt 0 on the first edge with rst_n high.
REQ-027 Reset output values SHALL be busy=1 and all rd=0.

Configuration
REQ-028 With macro REGFILE_MP_BYPASS_EN defined: when busy=0, we=1, wa == ra[i] and wa != PC_IDX, rd[i] SHALL equal wd in the same cycle.
REQ-029 Without REGFILE_MP_BYPASS_EN: no bypass path SHALL exist, and REQ-024 SHALL apply.

Structure
REQ-030 Package regfile_mp_pkg SHALL hold the FSM state enum (CLEAR, READY) and the default width/depth constants.
REQ-031 Sub-module regfile_mp_clear_fsm SHALL contain the state register and clr_cnt, and output busy, clr_we and clr_addr.
REQ-032 Storage and read muxes SHALL remain in regfile_mp; the storage write port SHALL be muxed between the clear sweep and the user write.

Verification
REQ-033 Reset sweep: rst_n=0 for 2 edges, then 1 -> busy=1 for exactly 16 edges, then 0; ra={3,7} -> rd={0,0}.
REQ-034 Write/read: write 0xDEADBEEF to r5, next cycle ra[0]=5 -> rd[0]=0xDEADBEEF; ra[1]=5 concurrently -> same value.
REQ-035 PC port: write 0x1234 to r15, pc_in=0x00000108, ra[0]=15 -> rd[0]=0x00000108; storage unchanged.
REQ-036 Bypass: r2=0x11; same cycle we=1, wa=2, wd=0x22, ra[0]=2 -> rd[0]=0x22 with REGFILE_MP_BYPASS_EN, 0x11 without.
REQ-037 Busy write drop: during sweep, we=1, wa=9, wd=0xFF -> after sweep, r9 reads 0.
REQ-038 Mid-sweep reset: rst_n=0 at clr_cnt=8, then release -> busy high a further 16 edges; r0..r15 (excluding PC_IDX) read 0.

Source files
------------

// File: rtl/regfile_mp_pkg.sv
// Shared types and default sizing for the multi-port register file.
package regfile_mp_pkg;

  typedef enum logic [0:0] {
    StClear,
    StReady
  } state_e;

  localparam int unsigned DefDataW = 32;
  localparam int unsigned DefAddrW = 4;
  localparam int unsigned DefNread = 2;
  localparam int unsigned DefPcIdx = 15;

endpackage

// File: rtl/regfile_mp_clear_fsm.sv
// Post-reset clear sweep: walks every entry once, then holds READY until the next reset.
module regfile_mp_clear_fsm
  import regfile_mp_pkg::*;
#(
  parameter int unsigned ADDR_W = DefAddrW
) (
  input  logic              clk,
  input  logic              rst_n,
  output logic              busy,
  output logic              clr_we,
  output logic [ADDR_W-1:0] clr_addr
);

  state_e            state_q, state_d;
  logic [ADDR_W-1:0] cnt_q, cnt_d;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= StClear;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    busy    = 1'b0;
    clr_we  = 1'b0;
    unique case (state_q)
      StClear: begin
        busy   = 1'b1;
        clr_we = 1'b1;
        cnt_d  = cnt_q + 1'b1;
        // All-ones counter is the last entry, DEPTH = 2**ADDR_W
        if (cnt_q == '1) begin
          state_d = StReady;
        end
      end
      StReady: begin
        state_d = StReady;
      end
      default: begin
        state_d = StClear;
      end
    endcase
  end

  assign clr_addr = cnt_q;

endmodule

// File: rtl/regfile_mp.sv
// Multi-read-port register file with PC alias and post-reset clear sweep.
// Optional same-cycle write-to-read bypass enabled by defining REGFILE_MP_BYPASS_EN.
module regfile_mp
  import regfile_mp_pkg::*;
#(
  parameter int unsigned DATA_W = DefDataW,
  parameter int unsigned ADDR_W = DefAddrW,
  parameter int unsigned NREAD  = DefNread,
  parameter int unsigned PC_IDX = DefPcIdx
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         we,
  input  logic [ADDR_W-1:0]            wa,
  input  logic [DATA_W-1:0]            wd,
  input  logic [NREAD-1:0][ADDR_W-1:0] ra,
  input  logic [DATA_W-1:0]            pc_in,
  output logic [NREAD-1:0][DATA_W-1:0] rd,
  output logic                         busy
);

  localparam int unsigned       Depth  = 2 ** ADDR_W;
  localparam logic [ADDR_W-1:0] PcAddr = ADDR_W'(PC_IDX);

  logic [DATA_W-1:0] mem_q [Depth];

  logic              clr_we;
  logic [ADDR_W-1:0] clr_addr;
  logic              user_we;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_waddr;
  logic [DATA_W-1:0] mem_wdata;

  regfile_mp_clear_fsm #(
    .ADDR_W (ADDR_W)
  ) u_clear_fsm (
    .clk      (clk),
    .rst_n    (rst_n),
    .busy     (busy),
    .clr_we   (clr_we),
    .clr_addr (clr_addr)
  );

  assign user_we = we && (wa != PcAddr);

  always_comb begin
    if (busy) begin
      mem_we    = clr_we;
      mem_waddr = clr_addr;
      mem_wdata = '0;
    end else begin
      mem_we    = user_we;
      mem_waddr = wa;
      mem_wdata = wd;
    end
  end

  // Storage is never touched on an edge where reset is asserted
  always_ff @(posedge clk) begin
    if (rst_n && mem_we) begin
      mem_q[mem_waddr] <= mem_wdata;
    end
  end

  always_comb begin
    for (int i = 0; i < int'(NREAD); i++) begin
      rd[i] = '0;
      if (!busy) begin
        if (ra[i] == PcAddr) begin
          rd[i] = pc_in;
        end else begin
          rd[i] = mem_q[ra[i]];
`ifdef REGFILE_MP_BYPASS_EN
          // ra[i] already differs from PcAddr here, so wa does too
          if (we && (wa == ra[i])) begin
            rd[i] = wd;
          end
`else
`endif
        end
      end
    end
  end

endmodule

// File: tb/tb_regfile_mp.sv
// Randomized and directed bench for regfile_mp against an array-based reference model.
module tb_regfile_mp;

  localparam int DataW = 32;
  localparam int AddrW = 4;
  localparam int Nread = 2;
  localparam int PcIdx = 15;
  localparam int Depth = 16;

  logic                       clk = 1'b0;
  logic                       rst_n;
  logic                       we;
  logic [AddrW-1:0]           wa;
  logic [DataW-1:0]           wd;
  logic [Nread-1:0][AddrW-1:0] ra;
  logic [DataW-1:0]           pc_in;
  logic [Nread-1:0][DataW-1:0] rd;
  logic                       busy;

  regfile_mp u_dut (
    .clk   (clk),
    .rst_n (rst_n),
    .we    (we),
    .wa    (wa),
    .wd    (wd),
    .ra    (ra),
    .pc_in (pc_in),
    .rd    (rd),
    .busy  (busy)
  );

  always #5 clk = ~clk;

  int vectors = 0;
  int miscompares = 0;

  // Reference: entries plus number of entries cleared since the last reset (Depth = idle)
  logic [DataW-1:0] model [Depth];
  int               sweep_pos;

  task automatic check(input string tag, input logic [DataW-1:0] got,
                       input logic [DataW-1:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [DataW-1:0] exp_rd(input int a);
    if (sweep_pos < Depth) return '0;
    if (a == PcIdx) return pc_in;
`ifdef REGFILE_MP_BYPASS_EN
    if (we && (int'(wa) == a)) return wd;
`endif
    return model[a];
  endfunction

  function automatic void model_edge();
    if (!rst_n) begin
      sweep_pos = 0;
    end else if (sweep_pos < Depth) begin
      model[sweep_pos] = '0;
      sweep_pos++;
    end else if (we && (int'(wa) != PcIdx)) begin
      model[wa] = wd;
    end
  endfunction

  // Inputs are set just after an edge; outputs compared mid-cycle, then the edge is applied
  task automatic tick();
    #2;
    check("busy", {31'b0, busy}, {31'b0, (sweep_pos < Depth)});
    for (int i = 0; i < Nread; i++) begin
      check($sformatf("rd%0d[ra=%0d]", i, ra[i]), rd[i], exp_rd(int'(ra[i])));
    end
    @(posedge clk);
    model_edge();
    #1;
  endtask

  task automatic idle_inputs();
    we = 1'b0; wa = '0; wd = '0;
  endtask

  initial begin
    int busy_edges;
    for (int i = 0; i < Depth; i++) model[i] = '0;
    sweep_pos = 0;
    rst_n = 1'b0; pc_in = 32'h0000_0108;
    idle_inputs();
    ra[0] = 4'd3; ra[1] = 4'd7;

    // Two reset edges, then the sweep; a write at r9 mid-sweep must be dropped
    @(posedge clk); model_edge(); #1;
    check("reset_busy", {31'b0, busy}, 32'd1);
    check("reset_rd0", rd[0], '0);
    tick();
    rst_n = 1'b1;
    busy_edges = 0;
    for (int c = 0; c < 40 && busy; c++) begin
      if (c == 4) begin we = 1'b1; wa = 4'd9; wd = 32'hFF; end
      else idle_inputs();
      tick();
      busy_edges++;
    end
    check("sweep_len", busy_edges, 32'd16);
    idle_inputs();

    ra[0] = 4'd9; ra[1] = 4'd3;
    #2; check("r9_dropped", rd[0], '0);
    tick();

    // Write/read with both ports on the same entry
    we = 1'b1; wa = 4'd5; wd = 32'hDEAD_BEEF; tick();
    idle_inputs(); ra[0] = 4'd5; ra[1] = 4'd5;
    #2; check("r5_p0", rd[0], 32'hDEAD_BEEF); check("r5_p1", rd[1], 32'hDEAD_BEEF);
    tick();

    // PC alias; write to PC index is discarded
    we = 1'b1; wa = 4'd15; wd = 32'h1234; tick();
    idle_inputs(); ra[0] = 4'd15; pc_in = 32'h0000_0108;
    #2; check("pc_read", rd[0], 32'h0000_0108);
    tick();

    // Same-cycle write and read of r2
    we = 1'b1; wa = 4'd2; wd = 32'h11; tick();
    we = 1'b1; wa = 4'd2; wd = 32'h22; ra[0] = 4'd2;
`ifdef REGFILE_MP_BYPASS_EN
    #2; check("bypass_r2", rd[0], 32'h22);
`else
    #2; check("no_bypass_r2", rd[0], 32'h11);
`endif
    tick();
    idle_inputs();

    // Reset at clr_cnt 8 restarts the full sweep
    rst_n = 1'b0; tick(); rst_n = 1'b1;
    for (int c = 0; c < 8; c++) tick();
    rst_n = 1'b0; tick(); rst_n = 1'b1;
    busy_edges = 0;
    for (int c = 0; c < 40 && busy; c++) begin
      tick();
      busy_edges++;
    end
    check("resweep_len", busy_edges, 32'd16);
    for (int a = 0; a < Depth; a++) begin
      if (a == PcIdx) continue;
      ra[0] = AddrW'(a);
      #2; check($sformatf("clr_r%0d", a), rd[0], '0);
      tick();
    end

    // Random traffic with occasional resets
    for (int c = 0; c < 400; c++) begin
      rst_n = ($urandom_range(0, 63) != 0);
      we    = $urandom_range(0, 1);
      wa    = AddrW'($urandom_range(0, Depth - 1));
      wd    = $urandom;
      pc_in = $urandom;
      for (int i = 0; i < Nread; i++) ra[i] = AddrW'($urandom_range(0, Depth - 1));
      tick();
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
